// File: rtl/byte_input_handler.sv
// rtl/byte_input_handler.sv - reassembles a host byte stream into 13-byte command frames
// Frame: SYNC_BYTE, then command, address, data words (MSB first), with an inter-byte timeout.
module byte_input_handler #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hCD,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   input  logic        master_ready,
   output logic        in_ready,
   output logic [31:0] in_command,
   output logic [31:0] in_address,
   output logic [31:0] in_data,
   output logic        frame_error,
   output logic [15:0] error_count
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_COMMAND = 3'd1;
   localparam logic [2:0] ST_ADDRESS = 3'd2;
   localparam logic [2:0] ST_DATA    = 3'd3;
   localparam logic [2:0] ST_PRESENT = 3'd4;

   // Firing one count early registers frame_error as the counter reaches TIMEOUT_CYCLES-1.
   localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd2;

   logic [2:0]  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] tmo_q, tmo_d;
   logic [31:0] cmd_q, cmd_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] out_cmd_q, out_cmd_d;
   logic [31:0] out_addr_q, out_addr_d;
   logic [31:0] out_data_q, out_data_d;
   logic        byte_ready_q, byte_ready_d;
   logic        in_ready_q, in_ready_d;
   logic        frame_error_q, frame_error_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   logic accept;
   logic in_frame;

   assign accept   = byte_valid && byte_ready_q;
   assign in_frame = (state_q == ST_COMMAND) || (state_q == ST_ADDRESS) || (state_q == ST_DATA);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tmo_d         = tmo_q;
      cmd_d         = cmd_q;
      addr_d        = addr_q;
      data_d        = data_q;
      out_cmd_d     = out_cmd_q;
      out_addr_d    = out_addr_q;
      out_data_d    = out_data_q;
      in_ready_d    = 1'b0;
      frame_error_d = 1'b0;
      err_cnt_d     = err_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (accept && (byte_data == SYNC_BYTE)) begin
               state_d = ST_COMMAND;
               cnt_d   = 2'd0;
            end
         end
         ST_COMMAND: begin
            if (accept) begin
               cmd_d = {cmd_q[23:0], byte_data};
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = ST_ADDRESS;
            end
         end
         ST_ADDRESS: begin
            if (accept) begin
               addr_d = {addr_q[23:0], byte_data};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (accept) begin
               data_d = {data_q[23:0], byte_data};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  out_cmd_d  = cmd_q;
                  out_addr_d = addr_q;
                  out_data_d = {data_q[23:0], byte_data};
                  state_d    = ST_PRESENT;
               end
            end
         end
         ST_PRESENT: begin
            if (master_ready) begin
               in_ready_d = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // An accepted byte always beats the timeout in the same cycle.
      if (in_frame) begin
         if (accept) begin
            tmo_d = 32'd0;
         end else if (tmo_q == TIMEOUT_LAST) begin
            frame_error_d = 1'b1;
            state_d       = ST_IDLE;
            cnt_d         = 2'd0;
            tmo_d         = 32'd0;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
         end else begin
            tmo_d = tmo_q + 32'd1;
         end
      end else begin
         tmo_d = 32'd0;
      end

      byte_ready_d = (state_d != ST_PRESENT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 2'd0;
         tmo_q         <= 32'd0;
         cmd_q         <= 32'd0;
         addr_q        <= 32'd0;
         data_q        <= 32'd0;
         out_cmd_q     <= 32'd0;
         out_addr_q    <= 32'd0;
         out_data_q    <= 32'd0;
         byte_ready_q  <= 1'b0;
         in_ready_q    <= 1'b0;
         frame_error_q <= 1'b0;
         err_cnt_q     <= 16'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tmo_q         <= tmo_d;
         cmd_q         <= cmd_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         out_cmd_q     <= out_cmd_d;
         out_addr_q    <= out_addr_d;
         out_data_q    <= out_data_d;
         byte_ready_q  <= byte_ready_d;
         in_ready_q    <= in_ready_d;
         frame_error_q <= frame_error_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign byte_ready  = byte_ready_q;
   assign in_ready    = in_ready_q;
   assign in_command  = out_cmd_q;
   assign in_address  = out_addr_q;
   assign in_data     = out_data_q;
   assign frame_error = frame_error_q;
   assign error_count = err_cnt_q;

endmodule

// File: tb/tb_byte_input_handler.sv
// tb/tb_byte_input_handler.sv - randomized scoreboard bench for byte_input_handler
// Reference model parses the accepted byte stream into frames and tracks idle gaps.
module tb_byte_input_handler;

   localparam int          TMO  = 16;
   localparam logic [7:0]  SYNC = 8'hCD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        master_ready = 1'b1;
   logic        in_ready;
   logic [31:0] in_command;
   logic [31:0] in_address;
   logic [31:0] in_data;
   logic        frame_error;
   logic [15:0] error_count;

   always #5 clk = ~clk;

   byte_input_handler #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(32'd16)) dut (
      .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .master_ready(master_ready), .in_ready(in_ready),
      .in_command(in_command), .in_address(in_address), .in_data(in_data),
      .frame_error(frame_error), .error_count(error_count)
   );

   typedef struct {
      logic [31:0] c;
      logic [31:0] a;
      logic [31:0] d;
   } frame_t;

   frame_t      exp_q[$];
   int          total = 0;
   int          bad = 0;
   bit          rand_mr = 0;

   bit          in_frame = 0;
   logic [7:0]  fbuf[$];
   int          gap = 0;
   bit          pending = 0;
   int unsigned err_m = 0;
   bit          exp_ir = 0;
   bit          exp_fe = 0;
   bit          exp_br = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: predicts what the next rising edge produces from the current inputs.
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
         chk("rst_frame_error", {31'd0, frame_error}, 32'd0);
         chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
         chk("rst_error_count", {16'd0, error_count}, 32'd0);
         chk("rst_in_command", in_command, 32'd0);
         chk("rst_in_address", in_address, 32'd0);
         chk("rst_in_data", in_data, 32'd0);
         in_frame = 0; fbuf.delete(); gap = 0; pending = 0; err_m = 0;
         exp_ir = 0; exp_fe = 0; exp_br = 0;
         exp_q.delete();
      end else begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
         chk("frame_error", {31'd0, frame_error}, {31'd0, exp_fe});
         chk("byte_ready", {31'd0, byte_ready}, {31'd0, exp_br});
         chk("error_count", {16'd0, error_count}, err_m);
         exp_ir = pending && master_ready;
         if (exp_ir) pending = 0;
         exp_fe = 0;
         if (byte_valid && byte_ready) begin
            gap = 0;
            if (!in_frame) begin
               if (byte_data == SYNC) begin
                  in_frame = 1;
                  fbuf.delete();
               end
            end else begin
               fbuf.push_back(byte_data);
               if (fbuf.size() == 12) begin
                  frame_t f;
                  f.c = {fbuf[0], fbuf[1], fbuf[2], fbuf[3]};
                  f.a = {fbuf[4], fbuf[5], fbuf[6], fbuf[7]};
                  f.d = {fbuf[8], fbuf[9], fbuf[10], fbuf[11]};
                  exp_q.push_back(f);
                  in_frame = 0;
                  pending = 1;
               end
            end
         end else if (in_frame) begin
            gap++;
            if (gap == TMO - 1) begin
               exp_fe = 1;
               in_frame = 0;
               if (err_m < 65535) err_m++;
            end
         end
         exp_br = !pending;
      end
   end

   // Scoreboard monitor: pops an expected frame whenever the DUT presents one.
   always @(negedge clk) begin
      if (rst && in_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_frame", in_command, 32'hFFFF_FFFF ^ in_command);
         end else begin
            frame_t f;
            f = exp_q.pop_front();
            chk("in_command", in_command, f.c);
            chk("in_address", in_address, f.a);
            chk("in_data", in_data, f.d);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_mr) master_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      int n;
      ok = 0;
      n = 0;
      byte_valid = 1'b1;
      byte_data = b;
      while (!ok && n < 300) begin
         @(negedge clk);
         ok = byte_ready;
         tick();
         n++;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL send_byte_stall actual=byte_ready_low required=accept byte=%0h", b);
      end
      byte_valid = 1'b0;
   endtask

   // gap_idx selects which of the 13 bytes (0 = sync) is followed by an idle of gap_len cycles.
   task automatic send_frame(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d,
                             input int gapmax, input int gap_idx, input int gap_len);
      logic [103:0] w;
      w = {SYNC, c, a, d};
      for (int i = 0; i < 13; i++) begin
         if (gapmax > 0 && i > 0) idle($urandom_range(0, gapmax));
         send_byte(w[103 - 8*i -: 8]);
         if (i == gap_idx) idle(gap_len);
      end
   endtask

   initial begin
      #2 rst = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      idle(2);

      send_frame(32'h1, 32'h10, 32'hDEADBEEF, 0, -1, 0);
      idle(4);

      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
      send_frame(32'h1, 32'h10, 32'hDEADBEEF, 0, -1, 0);
      idle(4);

      master_ready = 1'b0;
      send_frame(32'hA5A5_0001, 32'h0000_1234, 32'hCAFE_F00D, 0, -1, 0);
      byte_valid = 1'b1;
      byte_data = 8'h55;
      idle(20);
      byte_valid = 1'b0;
      master_ready = 1'b1;
      idle(4);

      send_byte(SYNC); send_byte(8'h11); send_byte(8'h22);
      idle(30);
      send_frame(32'h2, 32'h3, 32'h4, 0, -1, 0);
      idle(4);

      send_frame(32'h1100_0000, 32'h10, 32'h77, 0, 1, TMO - 2);
      idle(4);
      send_frame(32'h1100_0000, 32'h10, 32'h77, 0, 1, TMO - 1);
      idle(4);
      send_frame(32'h5, 32'h6, 32'h7, 0, 12, 0);
      idle(4);

      send_byte(SYNC); send_byte(8'h00); send_byte(8'h00);
      rst = 1'b0;
      idle(3);
      rst = 1'b1;
      idle(2);
      send_frame(32'h1, 32'h10, 32'hDEADBEEF, 0, -1, 0);
      idle(4);

      send_frame(32'hCDCD_CDCD, 32'h0000_00CD, 32'hCD00_0000, 0, -1, 0);
      idle(4);

      rand_mr = 1;
      for (int k = 0; k < 40; k++) begin
         int ng;
         int glen;
         ng = $urandom_range(0, 2);
         for (int g = 0; g < ng; g++) send_byte(8'($urandom));
         case ($urandom_range(0, 5))
            0: glen = TMO - 2;
            1: glen = TMO - 1;
            2: glen = TMO + 4;
            default: glen = 0;
         endcase
         send_frame($urandom, $urandom, $urandom, 2, $urandom_range(0, 12), glen);
      end
      rand_mr = 0;
      master_ready = 1'b1;
      idle(40);

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
